// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: request/address out, ready/data back.
// Handshake: imem_req with imem_addr starts a fetch. Address is held until imem_ready.
// imem_ready qualifies imem_rdata for the current imem_addr in that cycle.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency imem handshake, and IF/ID register.
// A one-entry hold buffer keeps a word that arrives while fetch is stalled.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  stallD,
  input  logic                  flushD,
  input  logic                  pcsrcD,
  input  logic [31:0]           pcbranchD,
  input  logic                  jumpD,
  fetch_stage_if.master         imem,
  output logic [31:0]           pcF,
  output logic [31:0]           instrD,
  output logic [31:0]           pcplus4D,
  output logic                  validD,
  output logic                  fetch_busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic        r_redir_pend, w_redir_pend_nx;
  logic [31:0] r_redir_pc, w_redir_pc_nx;
  logic [31:0] r_hold_instr, w_hold_instr_nx;
  logic [31:0] r_hold_pc4, w_hold_pc4_nx;
  logic [31:0] r_instr, r_pc4;
  logic        r_valid;

  logic        w_ifid_load;
  logic [31:0] w_ifid_instr, w_ifid_pc4;
  logic        w_req, w_busy;
  logic        w_redirect;
  logic [31:0] w_target, w_jta, w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_jta      = {r_pc4[31:28], r_instr[25:0], 2'b00};
  assign w_redirect = (pcsrcD | jumpD) & ~stallD;
  assign w_target   = jumpD ? w_jta : pcbranchD;

  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_redir_pend_nx = r_redir_pend;
    w_redir_pc_nx   = r_redir_pc;
    w_hold_instr_nx = r_hold_instr;
    w_hold_pc4_nx   = r_hold_pc4;
    w_ifid_load     = 1'b0;
    w_ifid_instr    = r_hold_instr;
    w_ifid_pc4      = r_hold_pc4;
    w_req           = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      BOOT: begin
        w_busy     = 1'b1;
        w_state_nx = FETCH;
      end
      FETCH: begin
        w_req = 1'b1;
        if (imem.imem_ready) begin
          if (w_redirect) begin
            w_pc_nx         = w_target;
            w_redir_pend_nx = 1'b0;
          end else if (r_redir_pend) begin
            w_pc_nx         = r_redir_pc;
            w_redir_pend_nx = 1'b0;
          end else if (stallF) begin
            w_hold_instr_nx = imem.imem_rdata;
            w_hold_pc4_nx   = w_pc_plus4;
            w_state_nx      = HOLD;
          end else begin
            w_ifid_load  = 1'b1;
            w_ifid_instr = imem.imem_rdata;
            w_ifid_pc4   = w_pc_plus4;
            w_pc_nx      = w_pc_plus4;
          end
        end else begin
          // Redirect during a wait is remembered; the in-flight word is dropped on arrival.
          w_busy = 1'b1;
          if (w_redirect) begin
            w_redir_pend_nx = 1'b1;
            w_redir_pc_nx   = w_target;
          end
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_pc_nx    = w_target;
          w_state_nx = FETCH;
        end else if (!stallF && !stallD) begin
          // Buffered word is released only when IF/ID can actually take it.
          w_ifid_load = 1'b1;
          w_pc_nx     = w_pc_plus4;
          w_state_nx  = FETCH;
        end
      end
      default: w_state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= BOOT;
      r_pc         <= PC_RESET;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0;
      r_hold_instr <= 32'h0;
      r_hold_pc4   <= 32'h0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_redir_pend <= w_redir_pend_nx;
      r_redir_pc   <= w_redir_pc_nx;
      r_hold_instr <= w_hold_instr_nx;
      r_hold_pc4   <= w_hold_pc4_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (stallD) begin
      r_instr <= r_instr;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end else if (flushD || !w_ifid_load) begin
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_instr <= w_ifid_instr;
      r_pc4   <= w_ifid_pc4;
      r_valid <= 1'b1;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign pcF            = r_pc;
  assign instrD         = r_instr;
  assign pcplus4D       = r_pc4;
  assign validD         = r_valid;
  assign fetch_busy     = w_busy;
  assign o_dbg_state    = r_state;

endmodule
